// File: rtl/cell_select_cache.sv
// Tape-cell cache between decode and execute: lock-on-hit lookup, dirty writeback eviction, one memory transaction at a time.
// Hits and fill-cycle deliveries are combinational; misses stall through EVICT/FILL/WAIT until the fill cycle.
module cell_select_cache #(
    parameter int NENTRIES = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MEM_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       ins,
    input  logic [ADDR_W-1:0] ptr,
    input  logic              branch_en,
    output logic [15:0]       out_ins,
    output logic [DATA_W-1:0] val,
    output logic              stall,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int IDX_W = $clog2(NENTRIES);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, EVICT, FILL, WAIT} state_t;

    state_t state, state_nxt;

    logic [NENTRIES-1:0] e_valid, e_locked, e_dirty;
    logic [ADDR_W-1:0]   e_tag  [NENTRIES];
    logic [DATA_W-1:0]   e_data [NENTRIES];

    logic [IDX_W-1:0]  rr_ptr, victim;
    logic [ADDR_W-1:0] miss_addr;
    logic [CNT_W-1:0]  cnt;
    logic              branch_d1;

    logic [3:0] opcode;
    logic       lock_op, need, branching;

    assign opcode    = ins[15:12];
    assign lock_op   = (opcode == 4'd1) || (opcode == 4'd2);
    assign need      = lock_op || (opcode == 4'd5) || (opcode == 4'd8);
    assign branching = branch_en | branch_d1;

    logic             match_any, wb_any, inv_any, rr_any;
    logic [IDX_W-1:0] match_idx, wb_idx, inv_idx, rr_idx, cand;

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        wb_any    = 1'b0;
        wb_idx    = '0;
        inv_any   = 1'b0;
        inv_idx   = '0;
        rr_any    = 1'b0;
        rr_idx    = '0;
        cand      = '0;
        for (int i = 0; i < NENTRIES; i++) begin
            if (!match_any && e_valid[i] && (e_tag[i] == ptr)) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
            if (!wb_any && e_valid[i] && (e_tag[i] == wb_addr)) begin
                wb_any = 1'b1;
                wb_idx = IDX_W'(i);
            end
            if (!inv_any && !e_valid[i]) begin
                inv_any = 1'b1;
                inv_idx = IDX_W'(i);
            end
        end
        // Round-robin scan starting at rr_ptr; only consulted when every entry is valid.
        for (int k = 0; k < NENTRIES; k++) begin
            cand = rr_ptr + IDX_W'(k);
            if (!rr_any && !e_locked[cand]) begin
                rr_any = 1'b1;
                rr_idx = cand;
            end
        end
    end

    logic             lookup_ok, hit, locked_hit, miss, can_alloc;
    logic             fill_cycle, deliver_fill;
    logic [IDX_W-1:0] sel_idx;

    assign lookup_ok    = (state == IDLE) && need && !branching;
    assign hit          = lookup_ok && match_any && !e_locked[match_idx];
    assign locked_hit   = lookup_ok && match_any && e_locked[match_idx];
    assign miss         = lookup_ok && !match_any;
    assign can_alloc    = inv_any | rr_any;
    assign sel_idx      = inv_any ? inv_idx : rr_idx;
    assign fill_cycle   = (state == WAIT) && (cnt == CNT_W'(1));
    assign deliver_fill = fill_cycle && need && !branching && (ptr == miss_addr);

    assign stall   = (state == IDLE) ? (locked_hit | miss) : !deliver_fill;
    assign out_ins = (stall | branching) ? 16'h0000 : ins;
    assign val     = hit ? e_data[match_idx] : (deliver_fill ? mem_rdata : '0);

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            EVICT: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = e_tag[victim];
                mem_wdata = e_data[victim];
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = miss_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (miss && can_alloc) begin
                    state_nxt = (e_valid[sel_idx] && e_dirty[sel_idx]) ? EVICT : FILL;
                end
            end
            EVICT:   if (mem_gnt) state_nxt = FILL;
            FILL:    if (mem_gnt) state_nxt = WAIT;
            WAIT:    if (fill_cycle) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            e_valid   <= '0;
            e_locked  <= '0;
            e_dirty   <= '0;
            rr_ptr    <= '0;
            victim    <= '0;
            miss_addr <= '0;
            cnt       <= '0;
            branch_d1 <= 1'b0;
            for (int i = 0; i < NENTRIES; i++) begin
                e_tag[i]  <= '0;
                e_data[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            branch_d1 <= branch_en;

            if ((state == IDLE) && miss && can_alloc) begin
                victim    <= sel_idx;
                miss_addr <= ptr;
                rr_ptr    <= sel_idx + IDX_W'(1);
            end

            if (hit && lock_op) begin
                e_locked[match_idx] <= 1'b1;
            end

            if (wb_en && wb_any) begin
                e_data[wb_idx]   <= wb_data;
                e_locked[wb_idx] <= 1'b0;
                e_dirty[wb_idx]  <= 1'b1;
            end

            if ((state == EVICT) && mem_gnt) begin
                e_valid[victim] <= 1'b0;
                e_dirty[victim] <= 1'b0;
            end

            if ((state == FILL) && mem_gnt) begin
                cnt <= CNT_W'(MEM_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            // Fill write comes last so it owns the victim slot on this edge.
            if (fill_cycle) begin
                e_valid[victim]  <= 1'b1;
                e_dirty[victim]  <= 1'b0;
                e_locked[victim] <= deliver_fill && lock_op;
                e_tag[victim]    <= miss_addr;
                e_data[victim]   <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_cell_select_cache.sv
// Bench for cell_select_cache: directed scenarios then random traffic, checked against a tape/memory coherence model.
module tb_cell_select_cache;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ins = '0, ptr = '0;
    logic        branch_en = 1'b0;
    logic [15:0] out_ins, val;
    logic        stall;
    logic        wb_en = 1'b0;
    logic [15:0] wb_addr = '0, wb_data = '0;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0;
    logic [15:0] mem_rdata = '0;

    always #5 clk = ~clk;

    cell_select_cache #(.NENTRIES(4), .ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ins(ins), .ptr(ptr), .branch_en(branch_en),
        .out_ins(out_ins), .val(val), .stall(stall),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
    );

    int total = 0, passed = 0, cyc = 0;

    // mem: backing store; golden: architectural tape value each address must read as.
    logic [15:0] mem    [256];
    logic [15:0] golden [256];
    logic [15:0] lockq  [$];

    logic        d_rst = 1'b0, d_br = 1'b0, d_wb = 1'b0;
    logic [15:0] d_ins = '0, d_ptr = '0, d_wb_addr = '0, d_wb_data = '0;
    int          gnt_hold = 0;
    bit          gnt_rand = 1'b0;
    int          rd_due = -1;
    logic [15:0] rd_data = '0;
    logic        br_prev = 1'b0;
    logic        p_req = 1'b0, p_gnt = 1'b0, p_we = 1'b0;
    logic [15:0] p_addr = '0, p_wdata = '0;
    int          stall_run = 0;

    logic        s_stall, s_req, s_we;
    logic [15:0] s_val, s_out, s_addr, s_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit needs(input logic [3:0] op);
        return op inside {4'd1, 4'd2, 4'd5, 4'd8};
    endfunction

    task automatic monitor();
        logic deliver;
        check("out_ins", s_out, (s_stall || d_br || br_prev) ? 16'h0 : d_ins);
        deliver = (s_out != 16'h0) && needs(s_out[15:12]);
        if (deliver) begin
            check("val", s_val, golden[d_ptr[7:0]]);
            if (s_out[15:12] inside {4'd1, 4'd2}) lockq.push_back(d_ptr);
        end else begin
            check("val_idle", s_val, 16'h0);
        end
        if (p_req && !p_gnt) begin
            check("req_hold", s_req, 1'b1);
            check("we_hold", s_we, p_we);
            check("addr_hold", s_addr, p_addr);
            check("wdata_hold", s_wdata, p_wdata);
        end
        if (rd_due >= cyc) check("one_txn", s_req, 1'b0);
        if (s_req && mem_gnt) begin
            if (s_we) mem[s_addr[7:0]] = s_wdata;
            else begin
                rd_due  = cyc + MEM_LAT;
                rd_data = mem[s_addr[7:0]];
            end
        end
        if (d_wb) golden[d_wb_addr[7:0]] = d_wb_data;
        stall_run = s_stall ? stall_run + 1 : 0;
        if (stall_run > 200) check("stall_bound", stall_run, 0);
        p_req = s_req; p_gnt = mem_gnt; p_we = s_we; p_addr = s_addr; p_wdata = s_wdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        rst_n = d_rst; ins = d_ins; ptr = d_ptr; branch_en = d_br;
        wb_en = d_wb; wb_addr = d_wb_addr; wb_data = d_wb_data;
        mem_gnt = 1'b0;
        if (d_rst && mem_req) begin
            if (gnt_hold > 0) gnt_hold--;
            else mem_gnt = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        mem_rdata = (rd_due == cyc) ? rd_data : ~golden[d_ptr[7:0]];
        @(negedge clk);
        s_stall = stall; s_val = val; s_out = out_ins; s_req = mem_req;
        s_we = mem_we; s_addr = mem_addr; s_wdata = mem_wdata;
        if (d_rst) monitor();
        else begin
            rd_due = -1; lockq.delete(); p_req = 1'b0; stall_run = 0;
            for (int i = 0; i < 256; i++) golden[i] = mem[i];
        end
        br_prev = d_rst ? d_br : 1'b0;
        cyc++;
    endtask

    task automatic lookup(input logic [15:0] i, input logic [15:0] p);
        int n = 0;
        d_ins = i; d_ptr = p;
        do begin cycle(); n++; end while (s_stall && n < 50);
        check("lookup_done", s_stall, 1'b0);
    endtask

    task automatic do_reset();
        d_rst = 1'b0; d_ins = '0; d_br = 1'b0; d_wb = 1'b0;
        cycle();
        d_rst = 1'b1;
        cycle();
    endtask

    logic [3:0] ops [8];
    int n;

    initial begin
        ops = '{4'd1, 4'd2, 4'd5, 4'd8, 4'd0, 4'd3, 4'd7, 4'd9};
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'($urandom);
            golden[i] = mem[i];
        end
        mem[16'h10] = 16'h00AB; golden[16'h10] = 16'h00AB;

        // Reset state
        d_rst = 1'b0; cycle(); cycle();
        d_rst = 1'b1; d_ins = '0; cycle();
        check("rst_req", s_req, 1'b0);
        check("rst_we", s_we, 1'b0);
        check("rst_stall", s_stall, 1'b0);
        check("rst_out", s_out, 16'h0);
        check("rst_val", s_val, 16'h0);
        check("rst_addr", s_addr, 16'h0);
        check("rst_wdata", s_wdata, 16'h0);

        // Cold read
        d_ins = 16'h5000; d_ptr = 16'h0010;
        cycle(); check("cold_c0_stall", s_stall, 1'b1); check("cold_c0_req", s_req, 1'b0);
        cycle(); check("cold_req", s_req, 1'b1); check("cold_we", s_we, 1'b0);
        check("cold_addr", s_addr, 16'h0010); check("cold_c1_stall", s_stall, 1'b1);
        cycle(); check("cold_c2_stall", s_stall, 1'b1);
        cycle(); check("cold_fill_stall", s_stall, 1'b0); check("cold_fill_val", s_val, 16'h00AB);
        cycle(); check("cold_hit_stall", s_stall, 1'b0); check("cold_hit_req", s_req, 1'b0);
        check("cold_hit_val", s_val, 16'h00AB);

        // Delayed grant during FILL
        d_ptr = 16'h0020; gnt_hold = 5;
        cycle(); check("dg_miss_stall", s_stall, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("dg_hold_req", s_req, 1'b1);
            check("dg_hold_addr", s_addr, 16'h0020);
            check("dg_hold_stall", s_stall, 1'b1);
        end
        cycle(); check("dg_gnt_req", s_req, 1'b1);
        n = 0;
        do begin cycle(); n++; end while (s_stall && n < 10);
        check("dg_latency", n, MEM_LAT);

        // Lock / unlock
        d_ins = 16'h1000; d_ptr = 16'h0010;
        cycle(); check("lk_plus_stall", s_stall, 1'b0); check("lk_plus_val", s_val, 16'h00AB);
        d_ins = 16'h0000; d_wb = 1'b1; d_wb_addr = 16'h0010; d_wb_data = 16'h0005;
        cycle(); check("lk_pass_stall", s_stall, 1'b0);
        d_wb = 1'b0; d_ins = 16'h1000;
        cycle(); check("lk_plus5_val", s_val, 16'h0005);
        d_ins = 16'h5000;
        cycle(); check("lk_brz_stall", s_stall, 1'b1); check("lk_brz_req", s_req, 1'b0);
        cycle(); check("lk_brz_stall2", s_stall, 1'b1);
        d_wb = 1'b1; d_wb_data = 16'h0006;
        cycle(); check("lk_wb_nobypass", s_stall, 1'b1);
        d_wb = 1'b0;
        cycle(); check("lk_after_stall", s_stall, 1'b0); check("lk_after_val", s_val, 16'h0006);

        // Branch mid-miss
        d_ins = 16'h5000; d_ptr = 16'h0030;
        cycle(); cycle();
        d_br = 1'b1;
        cycle(); check("br_out0", s_out, 16'h0);
        d_br = 1'b0;
        cycle(); check("br_out1", s_out, 16'h0); check("br_noval", s_val, 16'h0);
        check("br_stall", s_stall, 1'b1);
        cycle(); check("br_hit_stall", s_stall, 1'b0); check("br_hit_req", s_req, 1'b0);

        // Dirty eviction with round-robin pointer at 1
        do_reset();
        for (int a = 0; a < 4; a++) lookup(16'h5000, 16'(a));
        lookup(16'h5000, 16'h0005);
        d_ins = 16'h1000; d_ptr = 16'h0001;
        cycle(); check("de_lock_stall", s_stall, 1'b0);
        d_ins = 16'h0000; d_wb = 1'b1; d_wb_addr = 16'h0001; d_wb_data = 16'h0007;
        cycle();
        d_wb = 1'b0; d_ins = 16'h5000; d_ptr = 16'h0004;
        cycle(); check("de_miss_stall", s_stall, 1'b1);
        cycle(); check("de_ev_req", s_req, 1'b1); check("de_ev_we", s_we, 1'b1);
        check("de_ev_addr", s_addr, 16'h0001); check("de_ev_wdata", s_wdata, 16'h0007);
        cycle(); check("de_fill_req", s_req, 1'b1); check("de_fill_we", s_we, 1'b0);
        check("de_fill_addr", s_addr, 16'h0004);
        lookup(16'h5000, 16'h0004);
        d_ptr = 16'h0005; cycle(); check("de_keep5", s_stall, 1'b0);
        d_ptr = 16'h0002; cycle(); check("de_keep2", s_stall, 1'b0);
        d_ptr = 16'h0001; cycle(); check("de_victim1_gone", s_stall, 1'b1);
        lookup(16'h5000, 16'h0001);

        // Reset mid-EVICT
        d_ins = 16'h1000; d_ptr = 16'h0003; cycle();
        d_ins = 16'h0000; d_wb = 1'b1; d_wb_addr = 16'h0003; d_wb_data = 16'h0099; cycle();
        d_wb = 1'b0; d_ins = 16'h5000; d_ptr = 16'h0006; gnt_hold = 3;
        cycle(); check("rs_miss_stall", s_stall, 1'b1);
        cycle(); check("rs_ev_req", s_req, 1'b1); check("rs_ev_we", s_we, 1'b1);
        check("rs_ev_addr", s_addr, 16'h0003);
        d_rst = 1'b0; d_ins = '0; cycle();
        d_rst = 1'b1; gnt_hold = 0;
        cycle(); check("rs_req_off", s_req, 1'b0); check("rs_stall_off", s_stall, 1'b0);
        for (int a = 1; a < 6; a += 2) begin
            d_ins = 16'h5000; d_ptr = 16'(a);
            cycle(); check("rs_all_miss", s_stall, 1'b1);
            lookup(16'h5000, 16'(a));
        end

        // Random traffic against the coherence model
        lockq.delete();
        gnt_rand = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (!s_stall) begin
                d_ins = {ops[$urandom_range(0, 7)], 12'($urandom)};
                d_ptr = 16'($urandom_range(0, 9));
            end
            d_br = ($urandom_range(0, 9) == 0);
            if (lockq.size() > 0 && $urandom_range(0, 1) == 1) begin
                d_wb = 1'b1; d_wb_addr = lockq.pop_front(); d_wb_data = 16'($urandom);
            end else begin
                d_wb = 1'b0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
